// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// State encoding, requester indices and default sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    localparam int REQ_ZXUNO = 0;
    localparam int REQ_AUX   = 1;

    localparam int FIFO_AW_DEF     = 4;
    localparam int AFULL_LVL_DEF   = 12;
    localparam int ACK_TIMEOUT_DEF = 4;

    // Almost-full compare against a FIFO occupancy count.
    function automatic logic is_afull(input int count, input int lvl);
        return count >= lvl;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// Generic synchronous FIFO with registered read data.
// Read data appears the cycle after a successful rd.
module uart_tx_arbiter_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  push;
    logic                  pop;

    assign full  = (data_count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty = (data_count == '0);
    assign push  = wr & ~full;
    assign pop   = rd & ~empty;

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            data_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                data_count <= data_count + 1'b1;
            end else if (pop && !push) begin
                data_count <= data_count - 1'b1;
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (pop) begin
            dout <= mem[rptr];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two
// byte sources, each with its own FIFO, gated by remote CTS.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int FIFO_AW     = FIFO_AW_DEF,
    parameter int AFULL_LVL   = AFULL_LVL_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic       clk_bus,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic       req0_stb,
    output logic       req0_afull,
    input  logic [7:0] req1_data,
    input  logic       req1_stb,
    output logic       req1_afull,
    output logic [1:0] ovf,
    input  logic [1:0] ovf_clr,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       cts_n,
    output logic       grant_id,
    output logic       active
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    state_t             state;
    state_t             state_next;
    logic               grant_next;
    logic               pick;
    logic [1:0]         fifo_rd;
    logic [1:0]         full;
    logic [1:0]         empty;
    logic [1:0]         avail;
    logic [7:0]         dout0;
    logic [7:0]         dout1;
    logic [FIFO_AW:0]   count0;
    logic [FIFO_AW:0]   count1;
    logic [ACK_W-1:0]   ack_cnt;
    logic               ack_expired;

    uart_tx_arbiter_fifo #(
        .ADDR_WIDTH (FIFO_AW),
        .DATA_WIDTH (8)
    ) u_fifo0 (
        .clk        (clk_bus),
        .reset      (reset),
        .wr         (req0_stb),
        .din        (req0_data),
        .rd         (fifo_rd[REQ_ZXUNO]),
        .dout       (dout0),
        .full       (full[REQ_ZXUNO]),
        .empty      (empty[REQ_ZXUNO]),
        .data_count (count0)
    );

    uart_tx_arbiter_fifo #(
        .ADDR_WIDTH (FIFO_AW),
        .DATA_WIDTH (8)
    ) u_fifo1 (
        .clk        (clk_bus),
        .reset      (reset),
        .wr         (req1_stb),
        .din        (req1_data),
        .rd         (fifo_rd[REQ_AUX]),
        .dout       (dout1),
        .full       (full[REQ_AUX]),
        .empty      (empty[REQ_AUX]),
        .data_count (count1)
    );

    assign avail       = ~empty;
    assign req0_afull  = is_afull(int'(count0), AFULL_LVL);
    assign req1_afull  = is_afull(int'(count1), AFULL_LVL);
    assign tx_start    = (state == ST_START);
    assign active      = (state != ST_IDLE);
    assign ack_expired = (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));

    // State and grant owner registers.
    always_ff @(posedge clk_bus) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant_id <= 1'b1;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
        end
    end

    // Next-state logic, round-robin pick and FIFO read strobes.
    always_comb begin
        state_next = state;
        grant_next = grant_id;
        fifo_rd    = 2'b00;
        pick       = grant_id;
        unique case (state)
            ST_IDLE: begin
                if (!cts_n && !tx_busy && (avail != 2'b00)) begin
                    if (avail == 2'b11) begin
                        pick = ~grant_id;
                    end else begin
                        pick = avail[REQ_AUX];
                    end
                    fifo_rd[pick] = 1'b1;
                    grant_next    = pick;
                    state_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_START;
            end
            ST_START: begin
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (ack_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Cycles spent waiting for the transmitter to acknowledge.
    always_ff @(posedge clk_bus) begin
        if (reset || state != ST_WAIT_ACK) begin
            ack_cnt <= '0;
        end else begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

    // Output byte is captured from the granted FIFO and held.
    always_ff @(posedge clk_bus) begin
        if (reset) begin
            tx_data <= 8'h00;
        end else if (state == ST_LOAD) begin
            tx_data <= grant_id ? dout1 : dout0;
        end
    end

    // Sticky overflow flags; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk_bus) begin
        if (reset) begin
            ovf <= 2'b00;
        end else begin
            ovf <= (ovf & ~ovf_clr) |
                   {req1_stb & full[REQ_AUX], req0_stb & full[REQ_ZXUNO]};
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter.
// Models the transmitter busy line and logs every tx_start.
module tb_uart_tx_arbiter;

    logic       clk_bus = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req0_data = 8'h00;
    logic       req0_stb = 1'b0;
    logic       req0_afull;
    logic [7:0] req1_data = 8'h00;
    logic       req1_stb = 1'b0;
    logic       req1_afull;
    logic [1:0] ovf;
    logic [1:0] ovf_clr = 2'b00;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       cts_n = 1'b1;
    logic       grant_id;
    logic       active;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_len = 0;
    int busy_cnt = 0;

    logic [7:0] q_data[$];
    int         q_cyc[$];
    logic       q_gid[$];

    uart_tx_arbiter dut (
        .clk_bus    (clk_bus),
        .reset      (reset),
        .req0_data  (req0_data),
        .req0_stb   (req0_stb),
        .req0_afull (req0_afull),
        .req1_data  (req1_data),
        .req1_stb   (req1_stb),
        .req1_afull (req1_afull),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .cts_n      (cts_n),
        .grant_id   (grant_id),
        .active     (active)
    );

    always #5 clk_bus = ~clk_bus;

    // Cycle counter and transmitter model: busy for busy_len cycles after start.
    always @(posedge clk_bus) begin
        cyc <= cyc + 1;
        if (tx_start && busy_len > 0) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign tx_busy = (busy_cnt != 0);

    // Log each start pulse with its byte, owner and cycle.
    always @(negedge clk_bus) begin
        if (tx_start) begin
            q_data.push_back(tx_data);
            q_cyc.push_back(cyc);
            q_gid.push_back(grant_id);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_bus);
        #1;
    endtask

    task automatic wait_cycle(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int i = 0; i < budget && q_data.size() < n; i++) tick();
    endtask

    task automatic push(input int r, input logic [7:0] d);
        tick();
        if (r == 0) begin
            req0_data = d;
            req0_stb  = 1'b1;
        end else begin
            req1_data = d;
            req1_stb  = 1'b1;
        end
        tick();
        req0_stb = 1'b0;
        req1_stb = 1'b0;
    endtask

    task automatic do_reset();
        cts_n    = 1'b1;
        busy_len = 0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wait_cycle(cyc + 25);
        q_data.delete();
        q_cyc.delete();
        q_gid.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data got %h want 00", tx_data);
        end
        n_checks++;
        if (tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tx_start got %b want 0", tx_start);
        end
        n_checks++;
        if (grant_id !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_grant_id got %b want 1", grant_id);
        end
        n_checks++;
        if (ovf !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ovf got %b want 00", ovf);
        end
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_active got %b want 0", active);
        end
        n_checks++;
        if ({req1_afull, req0_afull} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_afull got %b want 00", {req1_afull, req0_afull});
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        busy_len = 10;
        cts_n    = 1'b0;
        tick();
        c0        = cyc;
        req0_data = 8'hA5;
        req0_stb  = 1'b1;
        tick();
        req0_stb = 1'b0;
        wait_starts(1, 20);
        n_checks++;
        if (q_data.size() !== 1) begin
            n_fail++;
            $display("FAIL single_count got %0d want 1", q_data.size());
        end
        if (q_data.size() >= 1) begin
            n_checks++;
            if (q_cyc[0] !== c0 + 3) begin
                n_fail++;
                $display("FAIL single_latency got %0d want %0d", q_cyc[0], c0 + 3);
            end
            n_checks++;
            if (q_data[0] !== 8'hA5) begin
                n_fail++;
                $display("FAIL single_data got %h want a5", q_data[0]);
            end
            n_checks++;
            if (q_gid[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL single_grant got %b want 0", q_gid[0]);
            end
        end
        wait_cycle(c0 + 14);
        n_checks++;
        if (active !== 1'b1) begin
            n_fail++;
            $display("FAIL single_active_busy got %b want 1", active);
        end
        wait_cycle(c0 + 15);
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_active_done got %b want 0", active);
        end
        n_checks++;
        if (tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_hold got %h want a5", tx_data);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4];
        logic       exp_g [4];
        exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        busy_len = 3;
        push(0, 8'h10);
        push(0, 8'h11);
        push(1, 8'h20);
        push(1, 8'h21);
        cts_n = 1'b0;
        wait_starts(4, 100);
        n_checks++;
        if (q_data.size() !== 4) begin
            n_fail++;
            $display("FAIL rr_count got %0d want 4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== exp_d[i] || q_gid[i] !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d] got %h/%b want %h/%b",
                         i, q_data[i], q_gid[i], exp_d[i], exp_g[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (q_cyc[i] - q_cyc[i-1] !== 7) begin
                    n_fail++;
                    $display("FAIL rr_gap[%0d] got %0d want 7",
                             i, q_cyc[i] - q_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        busy_len = 2;
        for (int i = 0; i < 17; i++) begin
            push(1, 8'(i));
            if (i == 10) begin
                n_checks++;
                if (req1_afull !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_afull_11 got %b want 0", req1_afull);
                end
            end
            if (i == 11) begin
                n_checks++;
                if (req1_afull !== 1'b1 || req0_afull !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_afull_12 got %b%b want 10",
                             req1_afull, req0_afull);
                end
            end
            if (i == 15) begin
                n_checks++;
                if (ovf !== 2'b00) begin
                    n_fail++;
                    $display("FAIL ovf_16 got %b want 00", ovf);
                end
            end
        end
        n_checks++;
        if (ovf !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_17 got %b want 10", ovf);
        end
        tick();
        req1_stb = 1'b1;
        ovf_clr  = 2'b10;
        tick();
        req1_stb = 1'b0;
        ovf_clr  = 2'b00;
        n_checks++;
        if (ovf !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_set_wins got %b want 10", ovf);
        end
        ovf_clr = 2'b10;
        tick();
        ovf_clr = 2'b00;
        n_checks++;
        if (ovf !== 2'b00) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 00", ovf);
        end
        cts_n = 1'b0;
        wait_starts(16, 400);
        wait_cycle(cyc + 40);
        n_checks++;
        if (q_data.size() !== 16) begin
            n_fail++;
            $display("FAIL ovf_drain_count got %0d want 16", q_data.size());
        end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d] got %h want %h", i, q_data[i], 8'(i));
            end
        end
        n_checks++;
        if (req1_afull !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_afull_drained got %b want 0", req1_afull);
        end
    endtask

    task automatic test_flow();
        int g;
        do_reset();
        busy_len = 3;
        push(0, 8'h31);
        push(0, 8'h32);
        tick();
        g     = cyc;
        cts_n = 1'b0;
        tick();
        cts_n = 1'b1;
        wait_cycle(g + 40);
        n_checks++;
        if (q_data.size() !== 1) begin
            n_fail++;
            $display("FAIL flow_hold_count got %0d want 1", q_data.size());
        end
        if (q_data.size() >= 1) begin
            n_checks++;
            if (q_data[0] !== 8'h31 || q_cyc[0] !== g + 2) begin
                n_fail++;
                $display("FAIL flow_first got %h@%0d want 31@%0d",
                         q_data[0], q_cyc[0], g + 2);
            end
        end
        cts_n = 1'b0;
        wait_starts(2, 40);
        n_checks++;
        if (q_data.size() !== 2) begin
            n_fail++;
            $display("FAIL flow_resume_count got %0d want 2", q_data.size());
        end else if (q_data[1] !== 8'h32) begin
            n_fail++;
            $display("FAIL flow_resume_data got %h want 32", q_data[1]);
        end
    endtask

    task automatic test_ack_timeout();
        int t;
        do_reset();
        busy_len = 0;
        push(0, 8'h41);
        push(1, 8'h42);
        cts_n = 1'b0;
        wait_starts(1, 20);
        t = (q_cyc.size() >= 1) ? q_cyc[0] : cyc;
        n_checks++;
        if (q_data.size() < 1 || q_data[0] !== 8'h41) begin
            n_fail++;
            $display("FAIL ack_first got %0d starts want 41", q_data.size());
        end
        wait_cycle(t + 4);
        n_checks++;
        if (active !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_waiting got %b want 1", active);
        end
        wait_cycle(t + 5);
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_idle got %b want 0", active);
        end
        wait_starts(2, 30);
        n_checks++;
        if (q_data.size() !== 2) begin
            n_fail++;
            $display("FAIL ack_next_count got %0d want 2", q_data.size());
        end else if (q_data[1] !== 8'h42 || q_cyc[1] !== t + 7 || q_gid[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_next got %h@%0d/%b want 42@%0d/1",
                     q_data[1], q_cyc[1], q_gid[1], t + 7);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        busy_len = 20;
        for (int i = 0; i < 6; i++) push(0, 8'h50 + 8'(i));
        cts_n = 1'b0;
        wait_starts(1, 20);
        t = (q_cyc.size() >= 1) ? q_cyc[0] : cyc;
        wait_cycle(t + 3);
        n_checks++;
        if (active !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_active got %b want 1", active);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({active, tx_start, grant_id, ovf} !== 5'b00100 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got a%b s%b g%b o%b d%h want a0 s0 g1 o00 d00",
                     active, tx_start, grant_id, ovf, tx_data);
        end
        reset = 1'b0;
        wait_cycle(t + 60);
        n_checks++;
        if (q_data.size() !== 1) begin
            n_fail++;
            $display("FAIL mid_no_start got %0d starts want 1", q_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_flow();
        test_ack_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
